// File: rtl/nes_input_ports.sv
// $4016/$4017 controller port block: two joypad shift registers plus zapper merge on port 2.
// Optional turbo auto-fire is built only when NES_INPUT_TURBO_EN is defined.

module nes_pad_port #(
  parameter int MASK_OPPOSING = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       strobe,
  input  logic       rd,
  input  logic [7:0] joy,
  input  logic [1:0] turbo,
  input  logic       tphase,
  output logic       d0
);
  logic [7:0] eff;
  logic [7:0] sr;

  // Opposing-direction masking first, then turbo gating of A/B.
  always_comb begin
    eff = joy;
    if (MASK_OPPOSING != 0) begin
      if (joy[4] && joy[5]) eff[5:4] = 2'b00;
      if (joy[6] && joy[7]) eff[7:6] = 2'b00;
    end
`ifdef NES_INPUT_TURBO_EN
    if (turbo[0]) eff[0] = eff[0] & tphase;
    if (turbo[1]) eff[1] = eff[1] & tphase;
`endif
  end

`ifndef NES_INPUT_TURBO_EN
  logic unused_turbo;
  assign unused_turbo = ^{turbo, tphase};
`endif

  // Load beats shift; the 1-fill makes reads past the eighth return 1.
  always_ff @(posedge clk) begin
    if (reset)       sr <= 8'hFF;
    else if (strobe) sr <= eff;
    else if (rd)     sr <= {1'b1, sr[7:1]};
  end

  // While strobe is high the register is reloaded every clock, so show live A.
  assign d0 = strobe ? eff[0] : sr[0];
endmodule

module nes_input_ports #(
  parameter int MASK_OPPOSING = 1,
  parameter int TURBO_FRAMES  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       strobe,
  input  logic       rd_p1,
  input  logic       rd_p2,
  input  logic [7:0] joy1,
  input  logic [7:0] joy2,
  input  logic       zapper_en,
  input  logic       zap_light,
  input  logic       zap_trigger,
  input  logic       frame_tick,
  input  logic [1:0] turbo1,
  input  logic [1:0] turbo2,
  output logic [4:0] p1_data,
  output logic [4:0] p2_data
);
  localparam int NUM_PORTS = 2;

  logic [NUM_PORTS-1:0][7:0] joy;
  logic [NUM_PORTS-1:0][1:0] turbo;
  logic [NUM_PORTS-1:0]      rd;
  logic [NUM_PORTS-1:0]      d0;
  logic                      tphase;

  assign joy   = {joy2, joy1};
  assign turbo = {turbo2, turbo1};
  assign rd    = {rd_p2, rd_p1};

`ifdef NES_INPUT_TURBO_EN
  logic [3:0] fcnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      fcnt   <= 4'd0;
      tphase <= 1'b0;
    end else if (frame_tick) begin
      if (fcnt == 4'(TURBO_FRAMES - 1)) begin
        fcnt   <= 4'd0;
        tphase <= ~tphase;
      end else begin
        fcnt <= fcnt + 4'd1;
      end
    end
  end
`else
  logic unused_tick;
  assign unused_tick = frame_tick;
  assign tphase      = 1'b0;
`endif

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    nes_pad_port #(.MASK_OPPOSING(MASK_OPPOSING)) u_port (
      .clk    (clk),
      .reset  (reset),
      .strobe (strobe),
      .rd     (rd[i]),
      .joy    (joy[i]),
      .turbo  (turbo[i]),
      .tphase (tphase),
      .d0     (d0[i])
    );
  end

  assign p1_data = {4'b0000, d0[0]};
  // With the zapper plugged in there is no pad, so D0 is held low.
  assign p2_data = zapper_en ? {zap_trigger, zap_light, 3'b000} : {4'b0000, d0[1]};
endmodule

// File: tb/tb_nes_input_ports.sv
// Randomized + directed bench for nes_input_ports against a queue-based serial-read model.
module tb_nes_input_ports;
  localparam int MASK = 1;
  localparam int TF   = 2;

  logic       clk = 0;
  logic       reset = 1, strobe = 0, rd_p1 = 0, rd_p2 = 0;
  logic [7:0] joy1 = 0, joy2 = 0;
  logic       zapper_en = 0, zap_light = 1, zap_trigger = 0, frame_tick = 0;
  logic [1:0] turbo1 = 0, turbo2 = 0;
  logic [4:0] p1_data, p2_data;

  int checks = 0, errors = 0;

  // Model: bits still to be read, front of queue is next bit out.
  bit q1[$], q2[$];
  int ticks = 0;

  nes_input_ports #(.MASK_OPPOSING(MASK), .TURBO_FRAMES(TF)) dut (
    .clk(clk), .reset(reset), .strobe(strobe), .rd_p1(rd_p1), .rd_p2(rd_p2),
    .joy1(joy1), .joy2(joy2), .zapper_en(zapper_en), .zap_light(zap_light),
    .zap_trigger(zap_trigger), .frame_tick(frame_tick), .turbo1(turbo1),
    .turbo2(turbo2), .p1_data(p1_data), .p2_data(p2_data));

  always #5 clk = ~clk;

  function automatic bit turbo_on();
    // Phase flips every TF frames, starting low.
    return ((ticks / TF) % 2) == 1;
  endfunction

  function automatic logic [7:0] eff_of(input logic [7:0] j, input logic [1:0] t);
    logic [7:0] m;
    m = j;
    if (MASK != 0 && j[4] && j[5]) begin m[4] = 0; m[5] = 0; end
    if (MASK != 0 && j[6] && j[7]) begin m[6] = 0; m[7] = 0; end
`ifdef NES_INPUT_TURBO_EN
    if (t[0] && !turbo_on()) m[0] = 0;
    if (t[1] && !turbo_on()) m[1] = 0;
`else
    if (t == 2'b11) m = m; // turbo inputs have no effect in this build
`endif
    return m;
  endfunction

  task automatic load_q(inout bit q[$], input logic [7:0] v);
    q = {};
    for (int i = 0; i < 8; i++) q.push_back(v[i]);
  endtask

  function automatic logic [4:0] exp_p1();
    logic [7:0] e;
    e = eff_of(joy1, turbo1);
    return {4'b0, strobe ? e[0] : logic'(q1[0])};
  endfunction

  function automatic logic [4:0] exp_p2();
    logic [7:0] e;
    e = eff_of(joy2, turbo2);
    if (zapper_en) return {zap_trigger, zap_light, 3'b000};
    return {4'b0, strobe ? e[0] : logic'(q2[0])};
  endfunction

  // Advance one clock; model consumes the inputs that were present at the edge.
  task automatic step();
    logic [7:0] e1, e2;
    logic r, s, a, b, f;
    e1 = eff_of(joy1, turbo1); e2 = eff_of(joy2, turbo2);
    r = reset; s = strobe; a = rd_p1; b = rd_p2; f = frame_tick;
    @(posedge clk); #1;
    if (r) begin
      load_q(q1, 8'hFF); load_q(q2, 8'hFF); ticks = 0;
    end else begin
      if (s) begin
        load_q(q1, e1); load_q(q2, e2);
      end else begin
        if (a) begin void'(q1.pop_front()); q1.push_back(1'b1); end
        if (b) begin void'(q2.pop_front()); q2.push_back(1'b1); end
      end
      if (f) ticks++;
    end
  endtask

  task automatic test_reset();
    reset = 1; step(); reset = 0; #1;
    checks++;
    if (p1_data !== 5'b00001) begin errors++; $display("FAIL reset_p1 got %b exp %b", p1_data, 5'b00001); end
    checks++;
    if (p2_data !== 5'b00001) begin errors++; $display("FAIL reset_p2 got %b exp %b", p2_data, 5'b00001); end
  endtask

  task automatic test_read_order();
    logic [9:0] seq;
    seq = 10'b1100001001; // bit i = i-th read
    joy1 = 8'b0000_1001; strobe = 1; step(); strobe = 0; step();
    for (int i = 0; i < 10; i++) begin
      #1; checks++;
      if (p1_data[0] !== seq[i]) begin errors++; $display("FAIL read_order[%0d] got %b exp %b", i, p1_data[0], seq[i]); end
      rd_p1 = 1; step(); rd_p1 = 0; step();
    end
  endtask

  task automatic test_strobe_live();
    logic last;
    strobe = 1; joy1 = 8'h00;
    for (int i = 0; i < 3; i++) begin
      joy1[0] = ~joy1[0]; rd_p1 = 1; #1; checks++;
      if (p1_data[0] !== joy1[0]) begin errors++; $display("FAIL strobe_live[%0d] got %b exp %b", i, p1_data[0], joy1[0]); end
      step();
    end
    last = joy1[0]; rd_p1 = 0; strobe = 0; joy1 = 8'h00; #1; checks++;
    if (p1_data[0] !== last) begin errors++; $display("FAIL strobe_hold got %b exp %b", p1_data[0], last); end
  endtask

  task automatic test_mask();
    joy2 = 8'b0011_0000; strobe = 1; step(); strobe = 0; joy2 = 8'h00;
    for (int i = 0; i < 8; i++) begin
      #1; checks++;
      if (p2_data !== 5'b00000) begin errors++; $display("FAIL mask_read[%0d] got %b exp %b", i, p2_data, 5'b00000); end
      rd_p2 = 1; step(); rd_p2 = 0;
    end
  endtask

  task automatic test_zapper();
    zapper_en = 1; zap_light = 0; zap_trigger = 1; joy2 = 8'hFF;
    strobe = 1; step(); strobe = 0; #1; checks++;
    if (p2_data !== 5'b10000) begin errors++; $display("FAIL zap_dark got %b exp %b", p2_data, 5'b10000); end
    zap_light = 1; #1; checks++;
    if (p2_data !== 5'b11000) begin errors++; $display("FAIL zap_light got %b exp %b", p2_data, 5'b11000); end
    joy2 = 8'h02; strobe = 1; step(); strobe = 0;
    rd_p2 = 1; step(); rd_p2 = 0; zapper_en = 0; #1; checks++;
    if (p2_data !== 5'b00001) begin errors++; $display("FAIL zap_shift got %b exp %b", p2_data, 5'b00001); end
    zap_light = 1; zap_trigger = 0;
  endtask

  task automatic test_reset_mid();
    joy1 = 8'h00; strobe = 1; step(); strobe = 0;
    for (int i = 0; i < 4; i++) begin rd_p1 = 1; step(); rd_p1 = 0; end
    reset = 1; step(); reset = 0;
    for (int i = 0; i < 8; i++) begin
      rd_p1 = 1; #1; checks++;
      if (p1_data !== 5'b00001) begin errors++; $display("FAIL reset_mid[%0d] got %b exp %b", i, p1_data, 5'b00001); end
      step(); rd_p1 = 0;
    end
  endtask

  task automatic test_turbo();
    logic [4:0] e;
    reset = 1; step(); reset = 0;
    joy1 = 8'h01; turbo1 = 2'b01;
    for (int i = 0; i < 8; i++) begin
      frame_tick = 1; step(); frame_tick = 0;
      strobe = 1; step(); strobe = 0; #1;
      e = exp_p1(); checks++;
      if (p1_data !== e) begin errors++; $display("FAIL turbo[%0d] got %b exp %b", i, p1_data, e); end
    end
    turbo1 = 0;
  endtask

  task automatic test_random();
    logic [4:0] e1, e2;
    for (int i = 0; i < 600; i++) begin
      reset      = ($urandom_range(63) == 0);
      strobe     = ($urandom_range(7) == 0);
      rd_p1      = $urandom_range(1);
      rd_p2      = $urandom_range(1);
      joy1       = 8'($urandom); joy2 = 8'($urandom);
      turbo1     = 2'($urandom); turbo2 = 2'($urandom);
      frame_tick = ($urandom_range(3) == 0);
      zapper_en  = ($urandom_range(3) == 0);
      zap_light  = $urandom_range(1); zap_trigger = $urandom_range(1);
      #1; e1 = exp_p1(); e2 = exp_p2();
      checks++;
      if (p1_data !== e1) begin errors++; $display("FAIL rand_p1[%0d] got %b exp %b", i, p1_data, e1); end
      checks++;
      if (p2_data !== e2) begin errors++; $display("FAIL rand_p2[%0d] got %b exp %b", i, p2_data, e2); end
      step();
    end
    reset = 0; strobe = 0; rd_p1 = 0; rd_p2 = 0; frame_tick = 0; zapper_en = 0;
    turbo1 = 0; turbo2 = 0;
  endtask

  initial begin
    test_reset();
    test_read_order();
    test_strobe_live();
    test_mask();
    test_zapper();
    test_reset_mid();
    test_turbo();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
